// File: rtl/fgpio_seq.sv
// Fast-GPIO initiator: queues commands and replays them onto the fgpio req/ack bus with per-command idle gaps.
// FGPIO_SEQ_ABORT_ON_ERR_EN: an error ack drops the remaining queue and skips the delay.
module fgpio_seq #(
  parameter int DEPTH = 4,
  parameter int DLY_W = 16
) (
  input  logic             clk_neg_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [6:0]       cmd_funct7_i,
  input  logic [31:0]      cmd_rs1_i,
  input  logic [31:0]      cmd_rs2_i,
  input  logic [DLY_W-1:0] cmd_delay_i,
  output logic             fgpio_req_o,
  output logic [6:0]       fgpio_funct7_o,
  output logic [31:0]      fgpio_rs1_val_o,
  output logic [31:0]      fgpio_rs2_val_o,
  input  logic             fgpio_ack_i,
  input  logic             fgpio_error_i,
  input  logic [31:0]      fgpio_rd_val_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rd_val_o,
  output logic             rsp_error_o,
  output logic             err_sticky_o,
  output logic             busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

`ifdef FGPIO_SEQ_ABORT_ON_ERR_EN
  localparam bit AbortOnErr = 1'b1;
`else
  localparam bit AbortOnErr = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DELAY} state_e;

  state_e           state_q;
  logic             req_q;
  logic [DLY_W-1:0] cnt_q;
  logic             init_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             rsp_valid_q, rsp_err_q, err_sticky_q;
  logic [31:0]      rsp_rd_q;

  logic [6:0]       mem_f7_q  [DEPTH];
  logic [31:0]      mem_rs1_q [DEPTH];
  logic [31:0]      mem_rs2_q [DEPTH];
  logic [DLY_W-1:0] mem_dly_q [DEPTH];

  logic             full_w, ack_w, abort_w, push_w, pop_w;
  logic [DLY_W-1:0] head_dly_w;

  assign full_w     = (count_q == CW'(DEPTH));
  // An ack in a flush cycle is ignored entirely: no pop, no response, no sticky.
  assign ack_w      = (state_q == ISSUE) && fgpio_ack_i && !flush_i;
  assign abort_w    = AbortOnErr && ack_w && fgpio_error_i;
  assign pop_w      = ack_w;
  assign head_dly_w = mem_dly_q[rd_ptr_q];

  // init_q keeps ready low until the first edge after reset release.
  assign cmd_ready_o = init_q && !flush_i && !full_w && !abort_w;
  assign push_w      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_neg_i) begin
    if (push_w) begin
      mem_f7_q[wr_ptr_q]  <= cmd_funct7_i;
      mem_rs1_q[wr_ptr_q] <= cmd_rs1_i;
      mem_rs2_q[wr_ptr_q] <= cmd_rs2_i;
      mem_dly_q[wr_ptr_q] <= cmd_delay_i;
    end
  end

  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else if (abort_w) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push_w, pop_w})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rd_q     <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q <= ISSUE;
            req_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (ack_w) begin
            rsp_valid_q <= 1'b1;
            rsp_rd_q    <= fgpio_rd_val_i;
            rsp_err_q   <= fgpio_error_i;
            req_q       <= 1'b0;
            if (fgpio_error_i) err_sticky_q <= 1'b1;
            if (abort_w || head_dly_w == '0) begin
              state_q <= IDLE;
            end else begin
              state_q <= DELAY;
              cnt_q   <= head_dly_w - 1'b1;
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fgpio_req_o     = req_q;
  assign fgpio_funct7_o  = req_q ? mem_f7_q[rd_ptr_q]  : '0;
  assign fgpio_rs1_val_o = req_q ? mem_rs1_q[rd_ptr_q] : '0;
  assign fgpio_rs2_val_o = req_q ? mem_rs2_q[rd_ptr_q] : '0;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rd_val_o = rsp_rd_q;
  assign rsp_error_o  = rsp_err_q;
  assign err_sticky_o = err_sticky_q;
  assign busy_o       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_fgpio_seq.sv
// Directed bench for fgpio_seq; the responder returns rd = rs1 ^ 32'hC0DE0000 and
// raises error when the issued rs1 equals err_rs1.
module tb_fgpio_seq;

  logic        clk_neg_i;
  logic        rst_ni;
  logic        flush_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [6:0]  cmd_funct7_i;
  logic [31:0] cmd_rs1_i;
  logic [31:0] cmd_rs2_i;
  logic [15:0] cmd_delay_i;
  logic        fgpio_req_o;
  logic [6:0]  fgpio_funct7_o;
  logic [31:0] fgpio_rs1_val_o;
  logic [31:0] fgpio_rs2_val_o;
  logic        fgpio_ack_i;
  logic        fgpio_error_i;
  logic [31:0] fgpio_rd_val_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rd_val_o;
  logic        rsp_error_o;
  logic        err_sticky_o;
  logic        busy_o;

  logic [31:0] err_rs1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cyc[$];
  logic [31:0] req_rs1[$];
  logic [31:0] rsp_rd[$];
  logic [31:0] rsp_err[$];

  fgpio_seq #(.DEPTH(4), .DLY_W(16)) dut (
    .clk_neg_i(clk_neg_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_funct7_i(cmd_funct7_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .cmd_delay_i(cmd_delay_i),
    .fgpio_req_o(fgpio_req_o), .fgpio_funct7_o(fgpio_funct7_o),
    .fgpio_rs1_val_o(fgpio_rs1_val_o), .fgpio_rs2_val_o(fgpio_rs2_val_o),
    .fgpio_ack_i(fgpio_ack_i), .fgpio_error_i(fgpio_error_i), .fgpio_rd_val_i(fgpio_rd_val_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rd_val_o(rsp_rd_val_o), .rsp_error_o(rsp_error_o),
    .err_sticky_o(err_sticky_o), .busy_o(busy_o)
  );

  assign fgpio_rd_val_i = fgpio_rs1_val_o ^ 32'hC0DE0000;
  assign fgpio_error_i  = fgpio_req_o && (fgpio_rs1_val_o == err_rs1);

  initial begin
    clk_neg_i = 1'b0;
    forever #10 clk_neg_i = ~clk_neg_i;
  end

  always @(posedge clk_neg_i) cyc <= cyc + 1;

  always @(negedge clk_neg_i) begin
    if (fgpio_req_o) begin
      req_cyc.push_back(cyc);
      req_rs1.push_back(fgpio_rs1_val_o);
    end
    if (rsp_valid_o) begin
      rsp_rd.push_back(rsp_rd_val_o);
      rsp_err.push_back({31'd0, rsp_error_o});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_neg_i);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic clr();
    req_cyc.delete();
    req_rs1.delete();
    rsp_rd.delete();
    rsp_err.delete();
  endtask

  task automatic drv(input logic v, input logic [6:0] f, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [15:0] d);
    cmd_valid_i  = v;
    cmd_funct7_i = f;
    cmd_rs1_i    = r1;
    cmd_rs2_i    = r2;
    cmd_delay_i  = d;
  endtask

  initial begin
    logic [31:0] exp_rdy;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    fgpio_ack_i = 1'b0;
    err_rs1 = 32'hFFFFFFFF;
    drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);

    // Reset state, and ready only after the first edge past release
    #2;
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_req", fgpio_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_sticky", err_sticky_o, 0);
    chk("rst_funct7", fgpio_funct7_o, 0);
    #3 rst_ni = 1'b1;
    #2;
    chk("rel_ready_before_edge", cmd_ready_o, 0);
    nxt(); mid();
    chk("rel_ready_after_edge", cmd_ready_o, 1);

    // Single command with immediate ack
    nxt();
    drv(1'b1, 7'b1000000, 32'h5, 32'hF, 16'd0);
    fgpio_ack_i = 1'b1;
    mid();
    chk("t1_req_at_push", fgpio_req_o, 0);
    nxt();
    drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    mid();
    chk("t1_req_idle", fgpio_req_o, 0);
    chk("t1_busy_queued", busy_o, 1);
    nxt(); mid();
    chk("t1_req", fgpio_req_o, 1);
    chk("t1_funct7", fgpio_funct7_o, 32'h40);
    chk("t1_rs1", fgpio_rs1_val_o, 32'h5);
    chk("t1_rs2", fgpio_rs2_val_o, 32'hF);
    nxt(); mid();
    chk("t1_req_drop", fgpio_req_o, 0);
    chk("t1_rsp_valid", rsp_valid_o, 1);
    chk("t1_rsp_rd", rsp_rd_val_o, 32'hC0DE0005);
    chk("t1_rsp_err", rsp_error_o, 0);
    chk("t1_busy_low", busy_o, 0);
    chk("t1_rs1_zero", fgpio_rs1_val_o, 0);
    nxt(); mid();
    chk("t1_rsp_one_cycle", rsp_valid_o, 0);

    // Spacing with delays 0, 3, 0
    nxt(); clr();
    drv(1'b1, 7'h01, 32'h11, 32'h0, 16'd0);
    nxt(); drv(1'b1, 7'h02, 32'h12, 32'h0, 16'd3);
    nxt(); drv(1'b1, 7'h03, 32'h13, 32'h0, 16'd0);
    nxt(); drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    repeat (10) nxt();
    mid();
    chk("t2_req_count", req_cyc.size(), 3);
    chk("t2_rsp_count", rsp_rd.size(), 3);
    if (req_cyc.size() == 3) begin
      chk("t2_gap_1", req_cyc[1] - req_cyc[0], 2);
      chk("t2_gap_2", req_cyc[2] - req_cyc[0], 7);
    end
    if (rsp_rd.size() == 3) chk("t2_rsp_rd_1", rsp_rd[1], 32'hC0DE0012);
    chk("t2_busy", busy_o, 0);

    // Backpressure: ack withheld for 4 cycles
    nxt(); clr();
    fgpio_ack_i = 1'b0;
    drv(1'b1, 7'h11, 32'hAAAA0001, 32'hBBBB0002, 16'd0);
    nxt(); drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      nxt(); mid();
      chk("t3_hold_req", fgpio_req_o, 1);
      chk("t3_hold_f7", fgpio_funct7_o, 32'h11);
      chk("t3_hold_rs1", fgpio_rs1_val_o, 32'hAAAA0001);
      chk("t3_hold_rs2", fgpio_rs2_val_o, 32'hBBBB0002);
      chk("t3_no_rsp", rsp_valid_o, 0);
    end
    nxt(); fgpio_ack_i = 1'b1; mid();
    chk("t3_ack_rs1", fgpio_rs1_val_o, 32'hAAAA0001);
    nxt(); fgpio_ack_i = 1'b0; mid();
    chk("t3_rsp_valid", rsp_valid_o, 1);
    chk("t3_rsp_rd", rsp_rd_val_o, 32'h6A740001);
    chk("t3_req_drop", fgpio_req_o, 0);
    chk("t3_busy", busy_o, 0);
    nxt(); mid();
    chk("t3_req_cycles", req_cyc.size(), 5);
    chk("t3_rsp_count", rsp_rd.size(), 1);

    // Full FIFO: 5 pushes with no ack, 5th refused
    for (int i = 0; i < 5; i++) begin
      nxt();
      drv(1'b1, 7'(7'h20 + i), 32'h41 + i, 32'h0, 16'd0);
      mid();
      exp_rdy = (i < 4) ? 32'd1 : 32'd0;
      chk("t4_ready", cmd_ready_o, exp_rdy);
    end
    nxt();
    drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    clr();
    fgpio_ack_i = 1'b1;
    repeat (10) nxt();
    mid();
    chk("t4_req_count", req_rs1.size(), 4);
    chk("t4_rsp_count", rsp_rd.size(), 4);
    if (req_rs1.size() == 4)
      for (int i = 0; i < 4; i++) chk("t4_order", req_rs1[i], 32'h41 + i);
    chk("t4_busy", busy_o, 0);
    chk("t4_sticky_clean", err_sticky_o, 0);

    // Error on 2nd of 3 commands
    nxt(); clr();
    err_rs1 = 32'h22;
    drv(1'b1, 7'h30, 32'h21, 32'h0, 16'd0);
    nxt(); drv(1'b1, 7'h31, 32'h22, 32'h0, 16'd0);
    nxt(); drv(1'b1, 7'h32, 32'h23, 32'h0, 16'd0);
    nxt(); drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    nxt(); mid();
    chk("t5_req_err_cmd", fgpio_req_o, 1);
    chk("t5_rs1_err_cmd", fgpio_rs1_val_o, 32'h22);
`ifdef FGPIO_SEQ_ABORT_ON_ERR_EN
    chk("t5_ready_in_err_ack", cmd_ready_o, 0);
`else
    chk("t5_ready_in_err_ack", cmd_ready_o, 1);
`endif
    nxt(); mid();
    chk("t5_rsp_valid", rsp_valid_o, 1);
    chk("t5_rsp_err", rsp_error_o, 1);
    chk("t5_rsp_rd", rsp_rd_val_o, 32'hC0DE0022);
    chk("t5_sticky", err_sticky_o, 1);
    repeat (6) nxt();
    mid();
`ifdef FGPIO_SEQ_ABORT_ON_ERR_EN
    chk("t5_req_count", req_rs1.size(), 2);
    chk("t5_rsp_count", rsp_err.size(), 2);
`else
    chk("t5_req_count", req_rs1.size(), 3);
    chk("t5_rsp_count", rsp_err.size(), 3);
    if (rsp_err.size() == 3) begin
      chk("t5_err_0", rsp_err[0], 0);
      chk("t5_err_1", rsp_err[1], 1);
      chk("t5_err_2", rsp_err[2], 0);
    end
`endif
    chk("t5_busy", busy_o, 0);
    chk("t5_sticky_held", err_sticky_o, 1);

    // Flush on the ack cycle with 2 entries queued; simultaneous push dropped
    nxt(); clr();
    fgpio_ack_i = 1'b0;
    err_rs1 = 32'h31;
    drv(1'b1, 7'h40, 32'h31, 32'h0, 16'd0);
    nxt(); drv(1'b1, 7'h41, 32'h32, 32'h0, 16'd0);
    nxt(); drv(1'b1, 7'h42, 32'h33, 32'h0, 16'd0);
    fgpio_ack_i = 1'b1;
    flush_i = 1'b1;
    mid();
    chk("t6_ready_in_flush", cmd_ready_o, 0);
    chk("t6_req", fgpio_req_o, 1);
    chk("t6_rs1", fgpio_rs1_val_o, 32'h31);
    chk("t6_sticky_before", err_sticky_o, 1);
    nxt();
    flush_i = 1'b0;
    fgpio_ack_i = 1'b0;
    drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    clr();
    mid();
    chk("t6_no_rsp", rsp_valid_o, 0);
    chk("t6_sticky_cleared", err_sticky_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_req", fgpio_req_o, 0);
    chk("t6_ready_after", cmd_ready_o, 1);
    repeat (3) nxt();
    mid();
    chk("t6_no_reissue", req_cyc.size(), 0);
    chk("t6_no_late_rsp", rsp_rd.size(), 0);

    // Asynchronous reset in the middle of DELAY with a response pulse live
    nxt(); clr();
    fgpio_ack_i = 1'b1;
    err_rs1 = 32'hFFFFFFFF;
    drv(1'b1, 7'h70, 32'h71, 32'h72, 16'd5);
    nxt(); drv(1'b0, 7'h0, 32'h0, 32'h0, 16'h0);
    nxt(); mid();
    chk("t7_req", fgpio_req_o, 1);
    nxt(); mid();
    chk("t7_rsp_live", rsp_valid_o, 1);
    chk("t7_busy_delay", busy_o, 1);
    rst_ni = 1'b0;
    #2;
    chk("t7_rst_req", fgpio_req_o, 0);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_rsp_valid", rsp_valid_o, 0);
    chk("t7_rst_rsp_rd", rsp_rd_val_o, 0);
    chk("t7_rst_ready", cmd_ready_o, 0);
    chk("t7_rst_rs1", fgpio_rs1_val_o, 0);
    rst_ni = 1'b1;
    nxt(); mid();
    chk("t7_ready_back", cmd_ready_o, 1);
    chk("t7_req_after", fgpio_req_o, 0);
    chk("t7_busy_after", busy_o, 0);
    repeat (3) nxt();
    mid();
    chk("t7_req_count", req_cyc.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
